// File: rtl/data_memory_if.sv
// Bus bundle for the MEM-stage data memory: address, store data, read/write
// enables and load data. The AddrError flag is only present when
// DATAMEM_BOUNDS_CHECK_EN is defined.
interface data_memory_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 24
);
  logic [ADDR_W-1:0] Adresa;
  logic [DATA_W-1:0] WriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] ReadData;
`ifdef DATAMEM_BOUNDS_CHECK_EN
  logic              AddrError;

  modport master (output Adresa, WriteData, MemWrite, MemRead,
                  input  ReadData, AddrError);
  modport slave  (input  Adresa, WriteData, MemWrite, MemRead,
                  output ReadData, AddrError);
`else
  modport master (output Adresa, WriteData, MemWrite, MemRead,
                  input  ReadData);
  modport slave  (input  Adresa, WriteData, MemWrite, MemRead,
                  output ReadData);
`endif
endinterface

// File: rtl/data_memory.sv
// Byte-addressed data memory for the 24-bit datapath MEM stage.
// A word is three consecutive bytes, big-endian, at any byte address.
// Writes happen on the rising clock edge; reads are combinational.
// Asynchronous active-low reset clears every byte.
// Optional feature macro: DATAMEM_BOUNDS_CHECK_EN
//   defined   -> bytes at index >= DEPTH are dropped on write, read as 0,
//                and AddrError flags the access.
//   undefined -> byte indices wrap modulo DEPTH.
module data_memory #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24,
  parameter int DEPTH  = 256
) (
  input  logic          Clock,
  input  logic          Resetn,
  data_memory_if.slave  bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q   [DEPTH];
  logic [ADDR_W:0]   sum_s   [3];
  logic [IDX_W-1:0]  idx_s   [3];
  logic [2:0]        inr_s;
  logic [7:0]        wbyte_s [3];
  logic [7:0]        rbyte_s [3];

  // Per-byte address decode: byte k of the word lives at Adresa+k.
  // The sum is one bit wider than the address so Adresa+2 never overflows.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sum_s[k] = {1'b0, bus.Adresa} + (ADDR_W+1)'(k);
`ifdef DATAMEM_BOUNDS_CHECK_EN
      inr_s[k] = (sum_s[k] < DEPTH_X);
      idx_s[k] = IDX_W'(sum_s[k]);
`else
      inr_s[k] = 1'b1;
      idx_s[k] = IDX_W'(sum_s[k] % DEPTH_X);
`endif
      wbyte_s[k] = bus.WriteData[DATA_W-1-8*k -: 8];
      rbyte_s[k] = inr_s[k] ? mem_q[idx_s[k]] : 8'h00;
    end
  end

  // Byte storage: cleared immediately on reset, written on the clock edge.
  // Reset takes priority, so a write in a reset cycle is lost.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (bus.MemWrite) begin
      for (int k = 0; k < 3; k++) begin
        if (inr_s[k]) begin
          mem_q[idx_s[k]] <= wbyte_s[k];
        end
      end
    end
  end

  // Load data is combinational so the result is ready in the same cycle;
  // no forwarding of the word being written this cycle.
  assign bus.ReadData = bus.MemRead ? {rbyte_s[0], rbyte_s[1], rbyte_s[2]}
                                    : {DATA_W{1'b0}};

`ifdef DATAMEM_BOUNDS_CHECK_EN
  // Flag any access whose last byte falls past the implemented array.
  assign bus.AddrError = (bus.MemRead | bus.MemWrite) & (sum_s[2] >= DEPTH_X);
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard testbench for data_memory: stimulus pushes expectations from a
// byte-array reference model, a monitor pops and compares them.
module tb_data_memory;

  localparam int DEPTH = 256;

  logic clk;
  logic rst_n;

  data_memory_if #(.ADDR_W(24), .DATA_W(24)) bus ();

  data_memory #(.DATA_W(24), .ADDR_W(24), .DEPTH(DEPTH)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [7:0] model_mem [DEPTH];

  string       name_q [$];
  logic [23:0] rd_q   [$];
  logic        ae_q   [$];
  event        check_ev;
  int          n_total;
  int          n_pass;

  function automatic logic [7:0] model_byte(longint a);
`ifdef DATAMEM_BOUNDS_CHECK_EN
    if (a >= DEPTH) return 8'h00;
    return model_mem[int'(a)];
`else
    return model_mem[int'(a % DEPTH)];
`endif
  endfunction

  function automatic logic [23:0] model_read(longint a, logic rd);
    if (!rd) return 24'h000000;
    return {model_byte(a), model_byte(a + 1), model_byte(a + 2)};
  endfunction

  task automatic model_write(longint a, logic [23:0] d);
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      b = d[23 - 8*k -: 8];
`ifdef DATAMEM_BOUNDS_CHECK_EN
      if (a + k < DEPTH) model_mem[int'(a + k)] = b;
`else
      model_mem[int'((a + k) % DEPTH)] = b;
`endif
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
  endtask

  task automatic check(string name);
    longint a;
    a = longint'(bus.Adresa);
    name_q.push_back(name);
    rd_q.push_back(model_read(a, bus.MemRead));
    ae_q.push_back((bus.MemRead || bus.MemWrite) && (a + 2 >= DEPTH));
    -> check_ev;
    #2;
  endtask

  // monitor: compare DUT outputs against queued expectations
  initial begin
    string       nm;
    logic [23:0] erd;
    logic        eae;
    n_total = 0;
    n_pass  = 0;
    forever begin
      @(check_ev);
      #1;
      while (rd_q.size() > 0) begin
        nm  = name_q.pop_front();
        erd = rd_q.pop_front();
        eae = ae_q.pop_front();
        n_total++;
        if (bus.ReadData !== erd)
          $display("FAIL %s: ReadData got %h want %h (addr %h)", nm, bus.ReadData, erd, bus.Adresa);
        else
          n_pass++;
`ifdef DATAMEM_BOUNDS_CHECK_EN
        n_total++;
        if (bus.AddrError !== eae)
          $display("FAIL %s: AddrError got %b want %b (addr %h)", nm, bus.AddrError, eae, bus.Adresa);
        else
          n_pass++;
`endif
      end
    end
  end

  task automatic do_write(longint a, logic [23:0] d);
    @(negedge clk);
    bus.Adresa    = 24'(a);
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    check("wr_pre");
    @(posedge clk);
    if (rst_n) model_write(a, d);
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  task automatic do_read(longint a, string name);
    @(negedge clk);
    bus.Adresa   = 24'(a);
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    check(name);
  endtask

  // stimulus
  initial begin
    int          op;
    longint      a;
    logic [23:0] d;

    rst_n         = 1'b0;
    bus.Adresa    = 24'h000002;
    bus.WriteData = 24'h000000;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    model_clear();
    #2;
    check("reset_idle");
    bus.MemRead = 1'b1;
    check("reset_rd");
    @(negedge clk);
    rst_n = 1'b1;
    bus.MemRead = 1'b0;

    // write and read back, byte layout
    do_write(2, 24'h123456);
    do_read(2, "wr_rd");
    do_read(3, "layout3");
    do_read(4, "layout4");

    // read gating
    @(negedge clk);
    bus.Adresa  = 24'h000002;
    bus.MemRead = 1'b0;
    check("rd_gate");

    // edge without MemWrite leaves memory unchanged
    @(negedge clk);
    bus.WriteData = 24'hFFFFFF;
    bus.MemWrite  = 1'b0;
    @(posedge clk);
    do_read(2, "we_off");

    // simultaneous read and write: old word before the edge, new after
    @(negedge clk);
    bus.Adresa    = 24'h00000A;
    bus.WriteData = 24'hABCDEF;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    check("simul_pre");
    @(posedge clk);
    model_write(10, 24'hABCDEF);
    check("simul_post");
    @(negedge clk);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;

    // asynchronous reset mid-cycle, then write blocked during reset
    do_read(2, "pre_rst");
    #1;
    rst_n = 1'b0;
    model_clear();
    check("rst_async");
    @(negedge clk);
    bus.Adresa    = 24'h000002;
    bus.WriteData = 24'h777777;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    @(posedge clk);
    check("rst_wr_block");
    @(negedge clk);
    bus.MemWrite = 1'b0;
    #2;
    rst_n = 1'b1;
    do_read(2, "post_rst");
    do_read(10, "post_rst10");

    // top-of-array boundary
    do_write(DEPTH - 1, 24'h010203);
    do_read(DEPTH - 1, "bnd_top");
    do_read(0, "bnd_0");
    do_read(DEPTH - 2, "bnd_m2");
    do_read(DEPTH - 3, "bnd_m3");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8) a = longint'($urandom_range(0, DEPTH + 4));
      else                          a = longint'($urandom & 32'h00FFFFFF);
      d = 24'($urandom);
      @(negedge clk);
      bus.Adresa    = 24'(a);
      bus.WriteData = d;
      bus.MemRead   = op[0];
      bus.MemWrite  = op[1];
      check("rnd_pre");
      @(posedge clk);
      if (op[1]) model_write(a, d);
      check("rnd_post");
    end

    @(negedge clk);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    #5;
    if (rd_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: pending %0d want 0", rd_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
